// File: rtl/mcu_pkg.sv
// Shared MCU definitions.
// Loader state encoding and instruction constants.
package mcu_pkg;

  localparam int OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] TERMINATE_OPCODE = 7'b0001011;

  localparam logic [1:0] BYTE_SIZE_ENCODE = 2'b00;
  localparam logic [1:0] WORD_SIZE_ENCODE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    WAIT,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// UART-to-program-memory bootloader.
// Streams bytes into PM until a terminate opcode or memory full.
module program_loader
  import mcu_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH   = 32,
  parameter int PROGRAM_MEMORY_SIZE = 64,
  parameter int ADDR_WIDTH_PM       = 8,
  parameter int CNT_WIDTH           = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_flag,
  output logic                     rx_use,
  output logic [DATA_WIDTH-1:0]    pm_data,
  output logic [ADDR_WIDTH_PM-1:0] pm_addr,
  output logic                     pm_wr_ins,
  input  logic                     pm_wr_idle,
  output logic                     loading,
  output logic                     load_done,
  output logic                     load_overflow,
  output logic [CNT_WIDTH-1:0]     instr_count
);

  localparam int LANES     = INSTRUCTION_WIDTH / DATA_WIDTH;
  localparam int LANE_W    = $clog2(LANES);
  localparam int LANE_LAST = LANES - 1;

  loader_state_t             state;
  logic [LANE_W-1:0]         lane;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [CNT_WIDTH-1:0]      count_next;

  // Pop and write strobes act in the cycle the handshake is seen.
  assign rx_use    = !rst && (state == FETCH) && rx_flag;
  assign pm_wr_ins = !rst && (state == WRITE) && pm_wr_idle;

  assign count_next = instr_count + CNT_WIDTH'(1);

  // Loader FSM with byte lane, opcode capture and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lane          <= '0;
      opcode        <= '0;
      pm_data       <= '0;
      pm_addr       <= '0;
      loading       <= 1'b0;
      load_done     <= 1'b0;
      load_overflow <= 1'b0;
      instr_count   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (load_start) begin
            state         <= FETCH;
            pm_addr       <= '0;
            lane          <= '0;
            instr_count   <= '0;
            load_done     <= 1'b0;
            load_overflow <= 1'b0;
            loading       <= 1'b1;
          end
        end
        FETCH: begin
          if (rx_flag) begin
            pm_data <= rx_data;
            if (lane == '0)
              opcode <= rx_data[OPCODE_WIDTH-1:0];
            state <= WRITE;
          end
        end
        WRITE: begin
          if (pm_wr_idle)
            state <= WAIT;
        end
        WAIT: begin
          if (pm_wr_idle)
            state <= CHECK;
        end
        CHECK: begin
          if (lane != LANE_W'(LANE_LAST)) begin
            lane    <= lane + LANE_W'(1);
            pm_addr <= pm_addr + ADDR_WIDTH_PM'(1);
            state   <= FETCH;
          end else begin
            lane        <= '0;
            instr_count <= count_next;
            if (opcode == TERMINATE_OPCODE) begin
              pm_addr   <= pm_addr + ADDR_WIDTH_PM'(1);
              loading   <= 1'b0;
              load_done <= 1'b1;
              state     <= DONE;
            end else if (count_next ==
                         CNT_WIDTH'(PROGRAM_MEMORY_SIZE)) begin
              // Address stays on the last byte: no wrap to 0.
              load_overflow <= 1'b1;
              loading       <= 1'b0;
              load_done     <= 1'b1;
              state         <= DONE;
            end else begin
              pm_addr <= pm_addr + ADDR_WIDTH_PM'(1);
              state   <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader.
// Vector table, corner sequences and random loads vs. a stream model.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       rx_use;
  logic [7:0] pm_data;
  logic [7:0] pm_addr;
  logic       pm_wr_ins;
  logic       pm_wr_idle;
  logic       loading;
  logic       load_done;
  logic       load_overflow;
  logic [6:0] instr_count;

  int total = 0;
  int bad   = 0;

  byte unsigned stream[$];
  byte unsigned fifo[$];
  int           wr_addr[$];
  int           wr_data[$];

  typedef struct {
    byte unsigned b[12];
    int           len;
    int           exp_n;
    bit           exp_ovf;
  } vec_t;

  vec_t vecs[5];

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .rx_data      (rx_data),
    .rx_flag      (rx_flag),
    .rx_use       (rx_use),
    .pm_data      (pm_data),
    .pm_addr      (pm_addr),
    .pm_wr_ins    (pm_wr_ins),
    .pm_wr_idle   (pm_wr_idle),
    .loading      (loading),
    .load_done    (load_done),
    .load_overflow(load_overflow),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rx_use"}, int'(rx_use), 0);
    chk({tag, " wr_ins"}, int'(pm_wr_ins), 0);
    chk({tag, " flags"},
        int'({loading, load_done, load_overflow}), 0);
    chk({tag, " addr"}, int'(pm_addr), 0);
    chk({tag, " data"}, int'(pm_data), 0);
    chk({tag, " count"}, int'(instr_count), 0);
  endtask

  // Words of 4 bytes; stop after a word whose first byte
  // carries the terminate opcode, else after 64 words.
  function automatic void model(output int n, output bit ovf);
    n   = 256;
    ovf = 1'b1;
    for (int w = 0; w < 64; w++) begin
      if (4 * w >= stream.size()) begin
        n   = stream.size();
        ovf = 1'b0;
        return;
      end
      if ((stream[4*w] & 8'h7f) == 8'h0b) begin
        n   = 4 * (w + 1);
        ovf = 1'b0;
        return;
      end
    end
  endfunction

  task automatic drive_rx(input bit avail);
    rx_flag = (fifo.size() > 0) && avail;
    rx_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic run_load(input string tag, input int exp_n,
                          input bit exp_ovf, input int stall_pct,
                          input int gap_pct, input int bp_at,
                          input int rst_at, input int restart_at);
    int  pops, bp_left, cyc, nchk;
    bit  bp_check, done, restarted;
    fifo = stream;
    wr_addr.delete();
    wr_data.delete();
    pm_wr_idle = 1'b1;
    drive_rx(1'b1);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk({tag, " loading_set"}, int'(loading), 1);
    pops = 0; bp_left = 0; bp_check = 0;
    cyc = 0; done = 0; restarted = 0;
    while (!done && cyc < 6000) begin
      if (bp_left > 0)
        pm_wr_idle = 1'b0;
      else if (bp_check)
        pm_wr_idle = 1'b1;
      else
        pm_wr_idle = ($urandom_range(99) >= stall_pct);
      drive_rx($urandom_range(99) >= gap_pct);
      load_start = 1'b0;
      if (restart_at >= 0 && pops == restart_at && !restarted) begin
        load_start = 1'b1;
        restarted  = 1'b1;
      end
      @(negedge clk);
      if (rx_use || pm_wr_ins)
        chk({tag, " excl"}, int'(rx_use && pm_wr_ins), 0);
      if (rx_use)
        chk({tag, " pop_flag"}, int'(rx_flag), 1);
      if (bp_left > 0) begin
        chk({tag, " bp_quiet"}, int'(rx_use || pm_wr_ins), 0);
        bp_left--;
        if (bp_left == 0)
          bp_check = 1'b1;
      end else if (bp_check) begin
        chk({tag, " bp_wr"}, int'(pm_wr_ins), 1);
        chk({tag, " bp_addr"}, int'(pm_addr), 2);
        bp_check = 1'b0;
      end
      if (pm_wr_ins) begin
        wr_addr.push_back(int'(pm_addr));
        wr_data.push_back(int'(pm_data));
      end
      if (rx_use) begin
        void'(fifo.pop_front());
        pops++;
        if (pops == bp_at)
          bp_left = 5;
      end
      if (load_done)
        done = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (rst_at >= 0 && pops == rst_at) begin
        rst = 1'b1;
        drive_rx(1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero({tag, " midrst"});
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    chk({tag, " done_seen"}, int'(done), 1);
    load_start = 1'b0;
    pm_wr_idle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rx(1'b1);
      @(negedge clk);
      chk({tag, " post_quiet"}, int'(rx_use || pm_wr_ins), 0);
      @(posedge clk); #1;
    end
    chk({tag, " nwrites"}, wr_addr.size(), exp_n);
    nchk = (wr_addr.size() < exp_n) ? wr_addr.size() : exp_n;
    for (int i = 0; i < nchk; i++) begin
      chk({tag, " wr_addr"}, wr_addr[i], i);
      chk({tag, " wr_data"}, wr_data[i], int'(stream[i]));
    end
    chk({tag, " count"}, int'(instr_count), exp_n / 4);
    chk({tag, " ovf"}, int'(load_overflow), int'(exp_ovf));
    chk({tag, " done"}, int'(load_done), 1);
    chk({tag, " loading"}, int'(loading), 0);
    chk({tag, " left"}, fifo.size(), stream.size() - exp_n);
  endtask

  function automatic void set_vec(input int k, input int len,
      input bit [95:0] bytes, input int n, input bit ovf);
    bit [95:0] tmp;
    tmp = bytes;
    for (int i = 0; i < 12; i++)
      vecs[k].b[i] = tmp[95 - 8*i -: 8];
    vecs[k].len     = len;
    vecs[k].exp_n   = n;
    vecs[k].exp_ovf = ovf;
  endfunction

  task automatic gen_random(input bit ovf_mode);
    int          nw;
    byte unsigned b;
    stream.delete();
    nw = ovf_mode ? 66 : $urandom_range(1, 12);
    for (int w = 0; w < nw; w++) begin
      b = 8'($urandom);
      if (!ovf_mode && w == nw - 1)
        b = {b[7], 7'h0b};
      else if ((b & 8'h7f) == 8'h0b)
        b = b ^ 8'h01;
      stream.push_back(b);
      for (int j = 1; j < 4; j++)
        stream.push_back(($urandom_range(3) == 0) ?
                         8'h0b : 8'($urandom));
    end
    for (int j = 0; j < 3; j++)
      stream.push_back(8'($urandom));
  endtask

  initial begin
    int  en;
    bit  eo;
    string nm;
    rst        = 1'b1;
    load_start = 1'b0;
    rx_flag    = 1'b1;
    rx_data    = 8'h13;
    pm_wr_idle = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle rx_use", int'(rx_use), 0);
      chk("idle loading", int'(loading), 0);
      @(posedge clk); #1;
    end

    set_vec(0, 9, 96'h13000000_0b000000_13000000, 8, 0);
    set_vec(1, 9, 96'h130b0000_0b000000_77000000, 8, 0);
    set_vec(2, 5, 96'h0b000000_13000000_00000000, 4, 0);
    set_vec(3, 5, 96'h8b112233_55000000_00000000, 4, 0);
    set_vec(4, 12, 96'h0f0b0b0b_0b0b0b0b_0b000000, 8, 0);
    for (int k = 0; k < 5; k++) begin
      stream.delete();
      for (int i = 0; i < vecs[k].len; i++)
        stream.push_back(vecs[k].b[i]);
      nm = $sformatf("vec%0d", k);
      run_load(nm, vecs[k].exp_n, vecs[k].exp_ovf, 0, 0, -1, -1, -1);
    end

    stream.delete();
    for (int i = 0; i < 9; i++)
      stream.push_back(vecs[0].b[i]);
    run_load("backpressure", 8, 0, 0, 0, 3, -1, -1);

    run_load("midrst", 8, 0, 0, 0, -1, 3, -1);
    run_load("restart", 8, 0, 20, 20, -1, -1, 5);

    stream.delete();
    for (int w = 0; w < 64; w++) begin
      stream.push_back(8'h13);
      stream.push_back(8'h00);
      stream.push_back(8'h00);
      stream.push_back(8'h00);
    end
    stream.push_back(8'h13);
    run_load("overflow", 256, 1, 0, 0, -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      gen_random(r == 5);
      model(en, eo);
      nm = $sformatf("rand%0d", r);
      run_load(nm, en, eo, 30, 30, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
